wdt_cfg_seq: RTL and testbench
==============================

Name: wdt_cfg_seq

Overview:
- Command-driven configuration sequencer for the watchdog timer peripheral.
- Turns high-level requests into correctly timed WDTCR I/O writes and wdri kicks: KICK, ENABLE, DISABLE and SETPS.
- DISABLE emits the atomic WDTOE/WDE two-write disable sequence, so the back-to-back timing is guaranteed.
- Also converts the watchdog timeout strobe into a stretched system reset pulse.

Parameters:
- WDTCR_ADDRESS, 6'h21: I/O address of the watchdog control register.
- RST_LEN, 16: wdt_rst_o pulse length in cycles. Legal range 1..2^RST_CNT_W-1.
- RST_CNT_W, 5: width of the reset stretch counter.

Ports:
- cp2  in  1  clock; all logic on the rising edge.
- ireset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_op  in  2  operation: 00 KICK, 01 ENABLE, 10 DISABLE, 11 SETPS.
- cmd_wdp  in  4  prescaler value for ENABLE/SETPS/DISABLE writes.
- cmd_wdie  in  1  WDIE value for the written WDTCR.
- cmd_ready  out  1  high when a command can be accepted.
- cmd_done  out  1  one-cycle pulse on command completion.
- io_adr  out  6  I/O address to the WDT; WDTCR_ADDRESS while io_we=1, else 0.
- io_dbus  out  8  write data to the WDT; 0 when io_we=0.
- io_we  out  1  I/O write strobe.
- wdri_o  out  1  watchdog reset (kick) strobe.
- wdtmout_i  in  1  watchdog timeout from the WDT.
- wdt_rst_o  out  1  stretched watchdog reset request.
- wde_o  out  1  shadow of the WDE state as programmed by this block.

Behaviour:
- Reset values:
  - All outputs 0, except cmd_ready=1.
  - FSM in IDLE; shadow WDE = 0; reset counter = 0.
- Accept and registering:
  - A command is accepted when cmd_valid & cmd_ready.
  - cmd_op, cmd_wdp and cmd_wdie are registered at acceptance.
  - All outputs are registered.
- cmd_ready = (state==IDLE) & ~wdt_rst_o.
- FSM states: IDLE, KICK, WRA, WRB.
- Transitions and latency (accept cycle = T):
  - KICK op: T+1 KICK state, wdri_o=1, cmd_done=1; T+2 IDLE.
  - ENABLE: T+1 KICK (wdri_o=1); T+2 WRB writes {wdie,0,0,1,wdp}, cmd_done=1; shadow WDE set to 1.
  - SETPS: T+1 KICK (wdri_o=1); T+2 WRB writes {wdie,0,0,shadowWDE,wdp}, cmd_done=1.
  - DISABLE:
    - T+1 WRA writes {wdie,0,1,1,wdp}.
    - T+2 WRB writes {wdie,0,0,0,wdp}, cmd_done=1; shadow WDE cleared.
    - WRA and WRB are always on consecutive cycles, which satisfies the WDT 4-cycle window.
- Write data bit 6 (WDIRQ) is always 0, so no IRQ flag is cleared. The optional feature below overrides this.
- Back-to-back commands: cmd_ready rises the cycle after cmd_done. The minimum spacing is 2 cycles for KICK and 3 cycles for the others.
- Timeout:
  - wdtmout_i=1 in any cycle while wdt_rst_o=0 loads the reset counter with RST_LEN and drives wdt_rst_o=1 from the next cycle for exactly RST_LEN cycles.
  - wdtmout_i while wdt_rst_o=1 is ignored; the counter is not restarted.
  - In the same cycle the timeout is taken:
    - any in-flight command is aborted (no cmd_done, no further writes);
    - the FSM goes to IDLE;
    - shadow WDE is cleared, matching the WDTCR reset.
- Simultaneous cmd_valid and wdtmout_i in IDLE: the timeout wins and the command is not accepted.
- ireset mid-operation: returns to reset values on the next edge; a partial DISABLE leaves no further writes.

Optional Feature:
- Macro: WDT_SEQ_IRQCLR_EN.
- Defined: adds input cmd_irqclr (1 bit), registered at acceptance. When set, bit 6 of the final write (WRB) is 1, clearing WDIRQ; WRA bit 6 stays 0.
- Undefined: the port is absent and bit 6 is always 0.

Decomposition:
- Shared package wdt_pkg:
  - op encodings OP_KICK/OP_ENABLE/OP_DISABLE/OP_SETPS;
  - WDTCR bit index constants WDIE=7, WDIRQ=6, WDTOE=5, WDE=4, WDP=3:0;
  - FSM state encodings.
- One natural sub-module, wdt_rst_stretch: the timeout capture and RST_LEN down-counter, with outputs wdt_rst_o and a busy flag.

Test Plan:
- Reset then KICK at T → wdri_o=1 only at T+1, cmd_done at T+1, io_we never asserted.
- ENABLE wdp=4'h7, wdie=1 → wdri_o at T+1; io_we at T+2 with io_adr=6'h21, io_dbus=8'h97; wde_o=1 afterwards.
- After ENABLE, DISABLE wdp=4'h7, wdie=0 → io_dbus=8'h37 at T+1, then 8'h07 at T+2; wde_o=0; against a WDT model, WDE reads 0.
- SETPS wdp=4'h2 with WDE enabled → kick, then write 8'h12; WDE remains set.
- wdtmout_i pulse at the WRA cycle of DISABLE, RST_LEN=16 → no WRB write, no cmd_done; wdt_rst_o high for exactly 16 cycles; cmd_ready low throughout; a second wdtmout pulse mid-reset does not extend it.
- cmd_valid held with wdtmout_i rising in the same IDLE cycle → command not accepted; accepted on the first cycle after wdt_rst_o falls.

Source files
------------

// File: rtl/wdt_pkg.sv
// wdt_pkg: shared op codes, WDTCR bit positions and sequencer states
package wdt_pkg;
  typedef enum logic [1:0] {OP_KICK = 2'b00, OP_ENABLE = 2'b01, OP_DISABLE = 2'b10, OP_SETPS = 2'b11} op_t;
  typedef enum logic [1:0] {S_IDLE, S_KICK, S_WRA, S_WRB} state_t;
  localparam int WDIE   = 7;
  localparam int WDIRQ  = 6;
  localparam int WDTOE  = 5;
  localparam int WDE    = 4;
  localparam int WDP_HI = 3;
  localparam int WDP_LO = 0;
endpackage

// File: rtl/wdt_rst_stretch.sv
// wdt_rst_stretch: captures a watchdog timeout and holds wdt_rst_o high for RST_LEN cycles
module wdt_rst_stretch #(
  parameter int RST_LEN   = 16,
  parameter int RST_CNT_W = 5
) (
  input  logic cp2,
  input  logic ireset,
  input  logic wdtmout_i,
  output logic wdt_rst_o,
  output logic busy
);
  localparam logic [RST_CNT_W-1:0] ONE = RST_CNT_W'(1);
  logic [RST_CNT_W-1:0] cnt;
  assign busy = |cnt;
  always_ff @(posedge cp2) begin
    if (ireset) begin
      cnt       <= '0;
      wdt_rst_o <= 1'b0;
    end else if (wdtmout_i & ~busy) begin
      cnt       <= RST_CNT_W'(RST_LEN);
      wdt_rst_o <= 1'b1;
    end else if (busy) begin
      cnt       <= cnt - ONE;
      wdt_rst_o <= cnt != ONE;
    end
  end
endmodule

// File: rtl/wdt_cfg_seq.sv
// wdt_cfg_seq: turns KICK/ENABLE/DISABLE/SETPS requests into timed WDTCR writes and wdri kicks
// WDT_SEQ_IRQCLR_EN adds cmd_irqclr, setting WDIRQ in the final write to clear the flag
module wdt_cfg_seq
  import wdt_pkg::*;
#(
  parameter logic [5:0] WDTCR_ADDRESS = 6'h21,
  parameter int         RST_LEN       = 16,
  parameter int         RST_CNT_W     = 5
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_wdp,
  input  logic       cmd_wdie,
`ifdef WDT_SEQ_IRQCLR_EN
  input  logic       cmd_irqclr,
`endif
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic [5:0] io_adr,
  output logic [7:0] io_dbus,
  output logic       io_we,
  output logic       wdri_o,
  input  logic       wdtmout_i,
  output logic       wdt_rst_o,
  output logic       wde_o
);
  state_t     state, state_n;
  op_t        op_r, op_c;
  logic [3:0] wdp_r, wdp_c;
  logic       wdie_r, wdie_c, irq_c;
  logic       busy, take, accept;
  logic       wdri_n, we_n, done_n, wde_n;
  logic [7:0] dbus_n;

  wdt_rst_stretch #(.RST_LEN(RST_LEN), .RST_CNT_W(RST_CNT_W)) u_rst (
    .cp2(cp2), .ireset(ireset), .wdtmout_i(wdtmout_i), .wdt_rst_o(wdt_rst_o), .busy(busy)
  );

  assign cmd_ready = (state == S_IDLE) & ~wdt_rst_o;
  assign take      = wdtmout_i & ~busy;
  assign accept    = cmd_valid & cmd_ready & ~take;
  // On the accept edge the first action is computed straight from the request
  assign op_c      = accept ? op_t'(cmd_op) : op_r;
  assign wdp_c     = accept ? cmd_wdp : wdp_r;
  assign wdie_c    = accept ? cmd_wdie : wdie_r;
`ifdef WDT_SEQ_IRQCLR_EN
  logic irq_r;
  assign irq_c = accept ? cmd_irqclr : irq_r;
  always_ff @(posedge cp2) begin
    if (ireset) irq_r <= 1'b0;
    else if (accept) irq_r <= cmd_irqclr;
  end
`else
  assign irq_c = 1'b0;
`endif

  always_ff @(posedge cp2) begin
    if (ireset) state <= S_IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = take ? S_IDLE :
              state == S_IDLE ? (accept ? (op_c == OP_DISABLE ? S_WRA : S_KICK) : S_IDLE) :
              state == S_KICK ? (op_c == OP_KICK ? S_IDLE : S_WRB) :
              state == S_WRA  ? S_WRB : S_IDLE;
    wdri_n  = state_n == S_KICK;
    we_n    = (state_n == S_WRA) | (state_n == S_WRB);
    done_n  = (state_n == S_WRB) | ((state_n == S_KICK) & (op_c == OP_KICK));
    wde_n   = take ? 1'b0 :
              state_n == S_WRB ? (op_c == OP_ENABLE) | ((op_c == OP_SETPS) & wde_o) : wde_o;
    dbus_n  = '0;
    if (we_n) begin
      dbus_n[WDIE]          = wdie_c;
      dbus_n[WDP_HI:WDP_LO] = wdp_c;
      dbus_n[WDIRQ]         = (state_n == S_WRB) & irq_c;
      dbus_n[WDTOE]         = state_n == S_WRA;
      dbus_n[WDE]           = (state_n == S_WRA) | wde_n;
    end
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      op_r     <= OP_KICK;
      wdp_r    <= '0;
      wdie_r   <= 1'b0;
      wdri_o   <= 1'b0;
      io_we    <= 1'b0;
      io_adr   <= '0;
      io_dbus  <= '0;
      cmd_done <= 1'b0;
      wde_o    <= 1'b0;
    end else begin
      if (accept) begin
        op_r   <= op_t'(cmd_op);
        wdp_r  <= cmd_wdp;
        wdie_r <= cmd_wdie;
      end
      wdri_o   <= wdri_n;
      io_we    <= we_n;
      io_adr   <= we_n ? WDTCR_ADDRESS : '0;
      io_dbus  <= dbus_n;
      cmd_done <= done_n;
      wde_o    <= wde_n;
    end
  end
endmodule

// File: tb/tb_wdt_cfg_seq.sv
// tb_wdt_cfg_seq: directed + random stimulus against a cycle-scheduled transaction model
module tb_wdt_cfg_seq;
  localparam int NC = 2600;
  localparam int RST_LEN = 16;
  logic cp2 = 1'b0, ireset = 1'b1, cmd_valid = 1'b0, cmd_wdie = 1'b0, wdtmout_i = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_wdp = 4'h0;
  logic cmd_ready, cmd_done, io_we, wdri_o, wdt_rst_o, wde_o;
  logic [5:0] io_adr;
  logic [7:0] io_dbus;
`ifdef WDT_SEQ_IRQCLR_EN
  logic cmd_irqclr = 1'b0;
`endif

  wdt_cfg_seq #(.WDTCR_ADDRESS(6'h21), .RST_LEN(RST_LEN), .RST_CNT_W(5)) dut (
    .cp2(cp2), .ireset(ireset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_wdp(cmd_wdp),
    .cmd_wdie(cmd_wdie),
`ifdef WDT_SEQ_IRQCLR_EN
    .cmd_irqclr(cmd_irqclr),
`endif
    .cmd_ready(cmd_ready), .cmd_done(cmd_done), .io_adr(io_adr), .io_dbus(io_dbus),
    .io_we(io_we), .wdri_o(wdri_o), .wdtmout_i(wdtmout_i), .wdt_rst_o(wdt_rst_o), .wde_o(wde_o)
  );

  always #5 cp2 = ~cp2;

  int checks = 0, failures = 0, cyc = 0;
  int free_at = 0, rst_lo = 1, rst_hi = 0;
  bit mwde = 1'b0;
  bit exp_wdri[NC], exp_we[NC], exp_done[NC];
  logic [7:0] exp_dbus[NC];
  int wde_evt[NC];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, got, want);
    end
  endtask

  function automatic bit rst_on(input int c);
    return c >= rst_lo && c <= rst_hi;
  endfunction

  function automatic void cancel_future(input int c);
    for (int k = c + 1; k <= c + 2; k++) begin
      exp_wdri[k] = 0; exp_we[k] = 0; exp_done[k] = 0; exp_dbus[k] = 8'h00; wde_evt[k] = -1;
    end
    wde_evt[c + 1] = 0;
    free_at = c + 1;
  endfunction

  // One cycle: check the outputs the model predicts for this cycle, then apply new inputs
  task automatic step(input bit v, input bit [1:0] op, input bit [3:0] wdp, input bit wdie,
                      input bit irq, input bit tm, input bit rs);
    bit ready_m;
    @(negedge cp2);
    if (wde_evt[cyc] >= 0) mwde = wde_evt[cyc] == 1;
    ready_m = cyc >= free_at && !rst_on(cyc);
    check("cmd_ready", {7'd0, cmd_ready}, {7'd0, ready_m});
    check("cmd_done", {7'd0, cmd_done}, {7'd0, exp_done[cyc]});
    check("wdri_o", {7'd0, wdri_o}, {7'd0, exp_wdri[cyc]});
    check("io_we", {7'd0, io_we}, {7'd0, exp_we[cyc]});
    check("io_adr", {2'd0, io_adr}, exp_we[cyc] ? 8'h21 : 8'h00);
    check("io_dbus", io_dbus, exp_dbus[cyc]);
    check("wdt_rst_o", {7'd0, wdt_rst_o}, {7'd0, rst_on(cyc)});
    check("wde_o", {7'd0, wde_o}, {7'd0, mwde});
    cmd_valid = v; cmd_op = op; cmd_wdp = wdp; cmd_wdie = wdie; wdtmout_i = tm; ireset = rs;
`ifdef WDT_SEQ_IRQCLR_EN
    cmd_irqclr = irq;
`else
    irq = 1'b0;
`endif
    if (rs) begin
      cancel_future(cyc);
      if (rst_hi > cyc) rst_hi = cyc;
    end else if (tm && !rst_on(cyc)) begin
      cancel_future(cyc);
      rst_lo = cyc + 1;
      rst_hi = cyc + RST_LEN;
    end else if (v && ready_m) begin
      case (op)
        2'b00: begin
          exp_wdri[cyc + 1] = 1; exp_done[cyc + 1] = 1; free_at = cyc + 2;
        end
        2'b10: begin
          exp_we[cyc + 1] = 1; exp_dbus[cyc + 1] = {wdie, 1'b0, 1'b1, 1'b1, wdp};
          exp_we[cyc + 2] = 1; exp_dbus[cyc + 2] = {wdie, irq, 1'b0, 1'b0, wdp};
          exp_done[cyc + 2] = 1; wde_evt[cyc + 2] = 0; free_at = cyc + 3;
        end
        default: begin
          bit nw;
          nw = (op == 2'b01) ? 1'b1 : mwde;
          exp_wdri[cyc + 1] = 1;
          exp_we[cyc + 2] = 1; exp_dbus[cyc + 2] = {wdie, irq, 1'b0, nw, wdp};
          exp_done[cyc + 2] = 1; wde_evt[cyc + 2] = nw ? 1 : 0; free_at = cyc + 3;
        end
      endcase
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, 4'h0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      exp_wdri[i] = 0; exp_we[i] = 0; exp_done[i] = 0; exp_dbus[i] = 8'h00; wde_evt[i] = -1;
    end
    repeat (2) @(posedge cp2);
    idle(2);
    step(1, 2'b00, 4'h3, 0, 0, 0, 0); idle(3);
    step(1, 2'b01, 4'h7, 1, 0, 0, 0); idle(3);
    step(1, 2'b10, 4'h7, 0, 0, 0, 0); idle(3);
    step(1, 2'b01, 4'h5, 0, 0, 0, 0); idle(3);
    step(1, 2'b11, 4'h2, 0, 0, 0, 0); idle(3);
    step(1, 2'b10, 4'h7, 0, 0, 0, 0);
    step(0, 2'b00, 4'h0, 0, 0, 1, 0); idle(7);
    step(0, 2'b00, 4'h0, 0, 0, 1, 0); idle(12);
    step(1, 2'b00, 4'h1, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, 2'b00, 4'h1, 0, 0, 0, 0);
    step(1, 2'b01, 4'h4, 1, 0, 0, 0);
    step(0, 2'b00, 4'h0, 0, 0, 0, 1);
    idle(3);
    step(1, 2'b01, 4'h6, 0, 0, 0, 0);
    step(1, 2'b01, 4'h6, 0, 0, 0, 0);
    step(1, 2'b01, 4'h6, 0, 0, 0, 0);
    step(1, 2'b10, 4'h9, 1, 1, 0, 0);
    step(0, 2'b00, 4'h0, 0, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 2300; i++)
      step($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 2, $urandom_range(0, 299) == 0);
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
